serial_operand_adder: RTL and testbench
=======================================

# serial_operand_adder

Bit-serial adder/subtractor that receives two operands as LSB-first serial bit streams and returns a parallel (WIDTH+1)-bit result with a one-cycle completion pulse. It is the receive-side counterpart to the lab's parallel-in, serially-processed adder. It sits downstream of any shifter that emits operand bits one per clock, and presents a registered parallel result for the 7-segment and LED display logic.

## Interface
- WIDTH, 8, operand width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; overrides every other input
- start  input  1  begins a new frame; latches `sub`; aborts any frame in progress
- sub  input  1  mode, sampled only with `start`: 0 = A+B, 1 = A−B
- a_bit  input  1  serial operand A bit, LSB first
- b_bit  input  1  serial operand B bit, LSB first
- bit_valid  input  1  `a_bit`/`b_bit` are valid this cycle
- busy  output  1  frame in progress (state RUN)
- done  output  1  one-cycle pulse; `sum`/`cout` updated this cycle
- sum  output  WIDTH+1  result; holds until next completion
- cout  output  1  raw final carry of the serial chain

## Operation
- Internal: state {IDLE, RUN}, carry flip-flop, bit counter (0..WIDTH−1), WIDTH-bit shift register, latched mode.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, shift register=0.
- IDLE:
  - `start`=1 → RUN; carry←`sub`; counter←0; mode←`sub`.
  - `bit_valid` is ignored.
- RUN, per cycle with `bit_valid`=1:
  - Effective operand bit b' = `b_bit` XOR mode.
  - s = `a_bit` ^ b' ^ carry.
  - carry ← majority(`a_bit`, b', carry).
  - Shift register shifts right with s inserted at bit WIDTH−1.
  - Counter increments.
- RUN with `bit_valid`=0: everything holds (stall). No limit on gaps.
- Final bit (counter = WIDTH−1 and `bit_valid`=1), on the same edge:
  - sum[WIDTH−1:0] ← {s, shreg[WIDTH−1:1]}.
  - cout ← carry_next.
  - sum[WIDTH] ← carry_next when mode=0, and ~carry_next (borrow) when mode=1, so a subtract result is the 9-bit two's-complement A−B.
  - done ← 1; state ← IDLE.
- `done` is high for exactly one cycle and low otherwise.
- `sum` and `cout` change only on a completion edge or on reset. They are not cleared by `start`.
- Boundary conditions:
  - `start` during RUN: frame aborted with no `done`; restarts as if from IDLE with the new `sub`; `bit_valid` in that cycle is ignored.
  - `start` in the cycle `done` is high: accepted (state is IDLE); back-to-back frames are allowed.
  - `start` and the final valid bit in the same cycle: `start` wins; the old frame is aborted with no `done`.
  - `reset` mid-frame: frame discarded; all outputs return to reset values on that edge.

## Timing
- `start` is sampled at edge 0. Bits are sampled at the first WIDTH edges after that with `bit_valid`=1.
- `busy`=1 from the cycle after the `start` edge until the cycle after the final-bit edge.
- `done`, `sum` and `cout` become visible in the cycle after the final-bit edge.
- Minimum latency from `start` to `done` is WIDTH+1 cycles (9 for WIDTH=8). Each stalled cycle adds 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add, no gaps: start with sub=0; stream A=0x5A, B=0xC3 LSB-first over 8 cycles → done 9 cycles after start; sum=9'h11D, cout=1.
- Subtract, negative result: sub=1, A=0x03, B=0x05 → sum=9'h1FE, cout=0. Subtract, positive result: A=0x05, B=0x03 → sum=9'h002, cout=1.
- Stalls: A=0xFF, B=0x01 with `bit_valid` low for 3 random cycles → sum=9'h100, cout=1; done 12 cycles after start; `busy` held throughout.
- Abort: start, send 4 bits, re-assert start with sub=0, then send A=0x10, B=0x20 → exactly one done pulse; sum=9'h030.
- Back-to-back: assert start in the done cycle of a 0x01+0x01 frame, then run 0x80+0x80 → first frame gives sum=9'h002; second gives sum=9'h100, cout=1, with no idle cycle between frames.
- Reset mid-frame: reset after 5 bits → sum=0, cout=0, busy=0, done=0 on the next cycle; a subsequent 0x0F+0x01 frame gives sum=9'h010.

Source files
------------

// File: rtl/serial_operand_adder_if.sv
// Bundle of the serial operand stream and the parallel result for serial_operand_adder.
// The master drives the operand bits and frame control; the slave returns the result.
interface serial_operand_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             a_bit;
  logic             b_bit;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             cout;

  modport master (
    output start, sub, a_bit, b_bit, bit_valid,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a_bit, b_bit, bit_valid,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_operand_adder.sv
// Bit-serial adder/subtractor: LSB-first operand streams in, registered (WIDTH+1)-bit result out.
// Subtraction is A + ~B + 1, with the +1 preloaded into the carry flop at frame start.
module serial_operand_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  serial_operand_adder_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned SHR_W = WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHR_W-1:0]   shreg_q, shreg_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               b_eff_c;
  logic               s_c;
  logic               carry_nxt_c;

  // One full-adder slice of the serial chain
  always_comb begin
    b_eff_c     = bus.b_bit ^ mode_q;
    s_c         = bus.a_bit ^ b_eff_c ^ carry_q;
    carry_nxt_c = (bus.a_bit & b_eff_c) | (bus.a_bit & carry_q) | (b_eff_c & carry_q);
  end

  // The final sum bit goes straight into the result, so only WIDTH-1 earlier bits are buffered
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    if (bus.start) begin
      state_d = RUN;
      carry_d = bus.sub;
      cnt_d   = '0;
      mode_d  = bus.sub;
    end else if (state_q == RUN && bus.bit_valid) begin
      carry_d = carry_nxt_c;
      shreg_d = (shreg_q >> 1) | (SHR_W'(s_c) << (SHR_W - 1));
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        sum_d   = {(mode_q ? ~carry_nxt_c : carry_nxt_c), s_c, shreg_q};
        cout_d  = carry_nxt_c;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_operand_adder.sv
// Scoreboard bench for serial_operand_adder: directed frames plus randomized frames with stalls,
// checked against an arithmetic reference model by a monitor that pops on every done pulse.
module tb_serial_operand_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   ticks;
  logic [W+1:0] exp_q[$];

  serial_operand_adder_if #(.WIDTH(W)) bus ();

  serial_operand_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  // {cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    int r;
    logic co;
    if (!s) begin
      r  = int'(a) + int'(b);
      co = (r >= (1 << W));
    end else begin
      r  = int'(a) - int'(b);
      co = (a >= b);
    end
    return {co, r[W:0]};
  endfunction

  task automatic monitor();
    logic prev_done;
    logic [W+1:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        chk("done_one_cycle", 32'(prev_done), 32'(0));
        if (exp_q.size() == 0) begin
          chk("done_without_frame", 32'(bus.done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(bus.sum), 32'(e[W:0]));
          chk("cout", 32'(bus.cout), 32'(e[W+1]));
        end
      end
      prev_done = bus.done;
    end
  endtask

  task automatic start_frame(input logic s);
    bus.start = 1'b1;
    bus.sub   = s;
    tick();
    bus.start = 1'b0;
    bus.sub   = 1'(s ^ 1'($urandom));
    chk("busy_after_start", 32'(bus.busy), 32'(1));
    chk("done_after_start", 32'(bus.done), 32'(0));
  endtask

  task automatic stream(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits,
                        input int nstall);
    int gaps[W];
    foreach (gaps[k]) gaps[k] = 0;
    repeat (nstall) gaps[$urandom_range(0, nbits - 1)]++;
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'($urandom);
        bus.b_bit     = 1'($urandom);
        tick();
        chk("busy_stall", 32'(bus.busy), 32'(1));
      end
      bus.bit_valid = 1'b1;
      bus.a_bit     = a[i];
      bus.b_bit     = b[i];
      tick();
      bus.bit_valid = 1'b0;
      if (i < int'(W) - 1) begin
        chk("busy_mid", 32'(bus.busy), 32'(1));
        chk("done_mid", 32'(bus.done), 32'(0));
      end
    end
  endtask

  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int nstall);
    int t0;
    t0 = ticks;
    exp_q.push_back(ref_model(a, b, s));
    start_frame(s);
    stream(a, b, int'(W), nstall);
    chk("done_at_end", 32'(bus.done), 32'(1));
    chk("busy_at_end", 32'(bus.busy), 32'(0));
    chk("latency", 32'(ticks - t0), 32'(int'(W) + 1 + nstall));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sum"},  32'(bus.sum),  32'(0));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           guard;
    n_vec = 0;
    n_err = 0;
    ticks = 0;
    reset = 1'b1;
    bus.start     = 1'b0;
    bus.sub       = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    bus.bit_valid = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed frames
    run_frame(8'h5A, 8'hC3, 1'b0, 0);
    tick();
    run_frame(8'h03, 8'h05, 1'b1, 0);
    tick();
    run_frame(8'h05, 8'h03, 1'b1, 0);
    tick();
    run_frame(8'hFF, 8'h01, 1'b0, 3);
    tick();

    // Abort: partial subtract frame, then restart as an add
    start_frame(1'b1);
    stream(8'hAA, 8'h55, 4, 1);
    run_frame(8'h10, 8'h20, 1'b0, 0);
    tick();

    // Back-to-back: second start lands in the done cycle
    run_frame(8'h01, 8'h01, 1'b0, 0);
    run_frame(8'h80, 8'h80, 1'b0, 0);
    tick();

    // Start coinciding with the final valid bit wins over completion
    start_frame(1'b0);
    stream(8'hFF, 8'hFF, int'(W) - 1, 0);
    bus.bit_valid = 1'b1;
    bus.a_bit     = 1'b1;
    bus.b_bit     = 1'b1;
    exp_q.push_back(ref_model(8'h21, 8'h42, 1'b1));
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    chk("collide_done", 32'(bus.done), 32'(0));
    chk("collide_busy", 32'(bus.busy), 32'(1));
    stream(8'h21, 8'h42, int'(W), 0);
    chk("collide_frame_done", 32'(bus.done), 32'(1));
    tick();

    // Reset mid-frame
    start_frame(1'b0);
    stream(8'h77, 8'h33, 5, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midreset");
    tick();
    run_frame(8'h0F, 8'h01, 1'b0, 0);
    tick();

    // Randomized frames, some back-to-back, some with stalls
    for (int f = 0; f < 40; f++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_frame(ra, rb, rs, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
